// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CTS  = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int NUM_REQ         = 2;
  localparam int DATA_W          = 7;
  localparam int CNT_W           = 8;
  localparam int WDOG_CYCLES_DEF = 32;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester, flow-control and transmitter signals of the UART transmit scheduler.
interface uart_tx_sched_if;
  import uart_pkg::*;

  logic [NUM_REQ-1:0] req_i;
  logic [DATA_W-1:0]  data0_i;
  logic [DATA_W-1:0]  data1_i;
  logic [NUM_REQ-1:0] ack_o;
  logic               cts;
  logic               rts;
  logic               tx_start;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_empty;
  logic               err_o;
  logic               err_clr_i;
  logic [CNT_W-1:0]   sent_cnt;

  // master: requesters, peer and transmitter; slave: the scheduler
  modport master (
    output req_i, data0_i, data1_i, cts, tx_empty, err_clr_i,
    input  ack_o, rts, tx_start, tx_data, err_o, sent_cnt
  );

  modport slave (
    input  req_i, data0_i, data1_i, cts, tx_empty, err_clr_i,
    output ack_o, rts, tx_start, tx_data, err_o, sent_cnt
  );

endinterface

// File: rtl/uart_rr_arb.sv
// Two-way round-robin pick: on contention the requester that did not go last wins.
module uart_rr_arb
  import uart_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic               valid,
  output logic               winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) winner = ~last_grant;
    else if (req[1])  winner = 1'b1;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates two character requesters onto one UART transmitter with
// RTS/CTS flow control, a per-character watchdog and a completed-character count.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input logic            baud_clk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);

  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] ack_r, ack_nxt;
  logic               rts_r, rts_nxt;
  logic               start_r, start_nxt;
  logic               err_r, err_nxt;
  logic [DATA_W-1:0]  data_r, data_nxt;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt;
  logic [7:0]         wdog_r, wdog_nxt, wdog_inc;
  logic               grant_r, grant_nxt;
  logic               last_grant, last_nxt;
  logic               arb_valid, arb_winner, wdog_hit;

  uart_rr_arb u_arb (
    .req        (bus.req_i),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  // Abort fires on the edge where the count reaches WDOG_CYCLES-1.
  assign wdog_inc = wdog_r + 8'd1;
  assign wdog_hit = (wdog_inc == WDOG_LAST);

  always_comb begin
    state_nxt = state;
    ack_nxt   = '0;
    rts_nxt   = rts_r;
    start_nxt = 1'b0;
    err_nxt   = err_r & ~bus.err_clr_i;
    data_nxt  = data_r;
    cnt_nxt   = cnt_r;
    wdog_nxt  = wdog_r;
    grant_nxt = grant_r;
    last_nxt  = last_grant;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          grant_nxt = arb_winner;
          data_nxt  = arb_winner ? bus.data1_i : bus.data0_i;
          ack_nxt   = arb_winner ? 2'b10 : 2'b01;
          rts_nxt   = 1'b1;
          state_nxt = WAIT_CTS;
        end
      end
      WAIT_CTS: begin
        if (bus.cts && bus.tx_empty) begin
          start_nxt = 1'b1;
          wdog_nxt  = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        wdog_nxt = wdog_inc;
        if (wdog_hit) begin
          err_nxt   = 1'b1;
          rts_nxt   = 1'b0;
          last_nxt  = grant_r;
          state_nxt = IDLE;
        end else if (!bus.tx_empty) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wdog_nxt = wdog_inc;
        if (bus.tx_empty) begin
          rts_nxt   = 1'b0;
          cnt_nxt   = cnt_r + 8'd1;
          last_nxt  = grant_r;
          state_nxt = IDLE;
        end else if (wdog_hit) begin
          err_nxt   = 1'b1;
          rts_nxt   = 1'b0;
          last_nxt  = grant_r;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ack_r      <= '0;
      rts_r      <= 1'b0;
      start_r    <= 1'b0;
      err_r      <= 1'b0;
      data_r     <= '0;
      cnt_r      <= '0;
      wdog_r     <= '0;
      grant_r    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      ack_r      <= ack_nxt;
      rts_r      <= rts_nxt;
      start_r    <= start_nxt;
      err_r      <= err_nxt;
      data_r     <= data_nxt;
      cnt_r      <= cnt_nxt;
      wdog_r     <= wdog_nxt;
      grant_r    <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  assign bus.ack_o    = ack_r;
  assign bus.rts      = rts_r;
  assign bus.tx_start = start_r;
  assign bus.err_o    = err_r;
  assign bus.tx_data  = data_r;
  assign bus.sent_cnt = cnt_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple transmitter model driving tx_empty.
module tb_uart_tx_sched;
  import uart_pkg::*;

  logic baud_clk = 1'b0;
  logic rst;
  always #5 baud_clk = ~baud_clk;

  uart_tx_sched_if bus();

  uart_tx_sched #(.WDOG_CYCLES(32)) dut (
    .baud_clk (baud_clk),
    .rst      (rst),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int start_cnt, ack0_cnt, ack1_cnt;
  int grant_q[$];
  int gdata_q[$];
  bit hang;
  int busy_left;
  bit pend;
  int a;
  bit ok;

  // Transmitter: goes busy one cycle after tx_start, for 10 cycles (or forever while hang).
  always @(negedge baud_clk) begin
    if (rst) begin
      bus.tx_empty = 1'b1;
      pend         = 1'b0;
      busy_left    = 0;
    end else begin
      if (pend) begin
        pend         = 1'b0;
        bus.tx_empty = 1'b0;
        busy_left    = 10;
      end else if (busy_left > 0) begin
        if (!hang) busy_left--;
        if (busy_left == 0) bus.tx_empty = 1'b1;
      end
      if (bus.tx_start) begin
        pend = 1'b1;
        start_cnt++;
      end
      if (bus.ack_o[0]) begin
        ack0_cnt++;
        grant_q.push_back(0);
        gdata_q.push_back(int'(bus.tx_data));
      end
      if (bus.ack_o[1]) begin
        ack1_cnt++;
        grant_q.push_back(1);
        gdata_q.push_back(int'(bus.tx_data));
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic clr_counts();
    start_cnt = 0;
    ack0_cnt  = 0;
    ack1_cnt  = 0;
    grant_q.delete();
    gdata_q.delete();
  endtask

  task automatic wait_ack(output int got);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge baud_clk);
      if (bus.ack_o != '0) begin
        got = int'(bus.ack_o);
        break;
      end
    end
  endtask

  task automatic send_one(input logic [1:0] r, input logic [6:0] d, output int got);
    bus.data0_i = d;
    bus.data1_i = d;
    bus.req_i   = r;
    wait_ack(got);
    bus.req_i   = 2'b00;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!bus.rts) break;
      @(negedge baud_clk);
    end
    chk(tag, int'(i < 200), 1);
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge baud_clk);
      if (bus.tx_start) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_abort(input bit clr_held);
    int got;
    bit seen;
    bus.err_clr_i = clr_held;
    send_one(2'b01, 7'h12, got);
    chk("wd_ack", got, 1);
    wait_start(seen);
    chk("wd_start_seen", int'(seen), 1);
    tick(30);
    chk("wd_err_early", int'(bus.err_o), 0);
    tick(1);
    chk("wd_err_set", int'(bus.err_o), 1);
    chk("wd_rts_low", int'(bus.rts), 0);
    chk("wd_cnt_same", int'(bus.sent_cnt), 6);
    hang = 1'b0;
    tick(15);
    bus.err_clr_i = 1'b1;
    tick(1);
    chk("wd_err_clr", int'(bus.err_o), 0);
    bus.err_clr_i = 1'b0;
    hang = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_i     = 2'b00;
    bus.data0_i   = '0;
    bus.data1_i   = '0;
    bus.cts       = 1'b0;
    bus.err_clr_i = 1'b0;
    hang          = 1'b0;
    clr_counts();
    tick(3);
    chk("rst_ack", int'(bus.ack_o), 0);
    chk("rst_rts", int'(bus.rts), 0);
    chk("rst_start", int'(bus.tx_start), 0);
    chk("rst_data", int'(bus.tx_data), 0);
    chk("rst_err", int'(bus.err_o), 0);
    chk("rst_cnt", int'(bus.sent_cnt), 0);
    rst = 1'b0;
    tick(2);

    // contention, first simultaneous request goes to requester 0
    bus.cts     = 1'b1;
    bus.data0_i = 7'h30;
    bus.data1_i = 7'h31;
    bus.req_i   = 2'b11;
    for (int i = 0; i < 400; i++) begin
      @(negedge baud_clk);
      if (bus.sent_cnt == 8'd4) break;
    end
    bus.req_i = 2'b00;
    chk("cont_cnt", int'(bus.sent_cnt), 4);
    tick(2);
    chk("cont_grants", grant_q.size(), 4);
    for (int k = 0; k < grant_q.size(); k++) begin
      chk("cont_order", grant_q[k], k % 2);
      chk("cont_data", gdata_q[k], 'h30 + (k % 2));
    end
    chk("cont_ack0", ack0_cnt, 2);
    chk("cont_ack1", ack1_cnt, 2);

    // single request
    clr_counts();
    send_one(2'b01, 7'h41, a);
    chk("single_ack", a, 1);
    chk("single_data", int'(bus.tx_data), 'h41);
    chk("single_rts", int'(bus.rts), 1);
    wait_idle("single_done");
    tick(2);
    chk("single_starts", start_cnt, 1);
    chk("single_ack0", ack0_cnt, 1);
    chk("single_ack1", ack1_cnt, 0);
    chk("single_cnt", int'(bus.sent_cnt), 5);
    chk("single_rts_low", int'(bus.rts), 0);
    chk("single_err", int'(bus.err_o), 0);

    // flow control, then cts dropped while in flight
    clr_counts();
    bus.cts = 1'b0;
    send_one(2'b01, 7'h55, a);
    chk("fc_ack", a, 1);
    tick(20);
    chk("fc_rts", int'(bus.rts), 1);
    chk("fc_nostart", start_cnt, 0);
    chk("fc_err", int'(bus.err_o), 0);
    bus.cts = 1'b1;
    tick(1);
    chk("fc_start_next", int'(bus.tx_start), 1);
    bus.cts = 1'b0;
    wait_idle("fc_done");
    tick(2);
    chk("fc_cnt", int'(bus.sent_cnt), 6);
    chk("fc_starts", start_cnt, 1);
    chk("fc_data", int'(bus.tx_data), 'h55);

    // watchdog abort, then abort colliding with err_clr_i
    bus.cts = 1'b1;
    hang    = 1'b1;
    run_abort(1'b0);
    run_abort(1'b1);
    hang = 1'b0;
    tick(15);

    // reset in the middle of a character
    send_one(2'b10, 7'h2A, a);
    chk("mid_ack", a, 2);
    wait_start(ok);
    chk("mid_start_seen", int'(ok), 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_ack", int'(bus.ack_o), 0);
    chk("mid_rst_rts", int'(bus.rts), 0);
    chk("mid_rst_start", int'(bus.tx_start), 0);
    chk("mid_rst_data", int'(bus.tx_data), 0);
    chk("mid_rst_err", int'(bus.err_o), 0);
    chk("mid_rst_cnt", int'(bus.sent_cnt), 0);
    tick(1);
    clr_counts();
    rst = 1'b0;
    tick(20);
    chk("post_rst_nostart", start_cnt, 0);
    chk("post_rst_rts", int'(bus.rts), 0);
    chk("post_rst_cnt", int'(bus.sent_cnt), 0);

    // 256 characters: count wraps back to zero
    bus.cts = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_one(2'b01, 7'(i), a);
      wait_idle("wrap_done");
      if (i == 254) chk("wrap_255", int'(bus.sent_cnt), 255);
    end
    tick(2);
    chk("wrap_cnt", int'(bus.sent_cnt), 0);
    chk("wrap_starts", start_cnt, 256);
    chk("wrap_acks", ack0_cnt, 256);
    chk("wrap_err", int'(bus.err_o), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
